sram_model: RTL and testbench
=============================

Name: sram_model

Overview:
- Behavioural single-port SRAM of 2**ADDR_WIDTH words × DATA_WIDTH bits, with a compile-time choice of synchronous (registered) or asynchronous (combinational) read.
- Used as the storage core under sram_image: one image pixel per word, flat address = x + y·X_MAX.
- Testbench tasks preload and dump contents hierarchically through the storage array, so the array name and shape are part of the interface.

Parameters:
- ADDR_WIDTH, 8: address bits; depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width in bits.
- RAM_IS_SYNCHRONOUS, 1: 1 = read data registered on ramclk; 0 = read data combinational from addr.

Ports:
- ramclk  input  1  Sole clock; all state updates on its rising edge.
- n_rst  input  1  Asynchronous active-low reset.
- addr  input  ADDR_WIDTH  Word address, shared by read and write.
- wen  input  1  Write enable.
- ren  input  1  Read enable.
- wdat  input  DATA_WIDTH  Write data.
- rdat  output  DATA_WIDTH  Read data.

Behaviour:
- Storage: unpacked array `ram`, indexed [0:DEPTH-1], each element logic [DATA_WIDTH-1:0].
  - Must stay hierarchically readable and writable (e.g. IMAGE_DUT.ram[i]) from tasks at any time.
  - Initial contents are all zero at time 0.
- Every address value is in range. Address all-ones is an ordinary word; sram_image uses it as its out-of-bounds sink.
- Write:
  - On posedge ramclk with n_rst=1 and wen=1: ram[addr] <= wdat.
  - Writes are ignored while n_rst=0.
  - n_rst does NOT clear ram; preloaded data survives reset.
- Synchronous read (RAM_IS_SYNCHRONOUS=1):
  - On posedge with n_rst=1 and ren=1: rdat <= ram[addr]. Latency is 1 cycle; data is valid after the edge that sampled ren.
  - With ren=0, rdat holds its last value.
  - Reset value of rdat is '0. Asserting n_rst asynchronously forces rdat to 0 immediately, and any read sampled in the same cycle is discarded.
- Asynchronous read (RAM_IS_SYNCHRONOUS=0):
  - rdat = ren ? ram[addr] : '0, combinationally.
  - n_rst has no effect on rdat.
- Simultaneous wen=1 and ren=1 at the same address:
  - Sync mode is read-first: rdat gets the old word, and the new word is stored.
  - Async mode: rdat shows the old word until the edge, then the new word.
- X/Z on addr while wen or ren is 1: the simulation model issues $error, performs no write, and drives rdat to 'x (sync mode: on the next edge).
- Mode selection uses a generate on RAM_IS_SYNCHRONOUS. Only the selected read path exists.

Decomposition:
- No shared package needed. DEPTH is a localparam derived from ADDR_WIDTH.
- No sub-module: write port, read register and async read path are small generate branches in one module.

Test Plan (ADDR_WIDTH=5, DATA_WIDTH=8 unless noted):
- Reset: assert n_rst=0 with ren=1 toggling -> rdat=8'h00 throughout; a prior ram preload of ram[3]=8'hA5 is still present after reset release.
- Write then read, sync: wen=1, addr=7, wdat=8'h3C for one cycle; next cycle ren=1, addr=7 -> rdat=8'h3C one cycle after the read edge; with ren then held 0, rdat stays 8'h3C.
- Read-first collision, sync: ram[9]=8'h11; in the same cycle wen=ren=1, addr=9, wdat=8'h22 -> rdat=8'h11 after the edge; a following read of 9 -> 8'h22.
- Boundary address: write 8'hFF to addr=31 and 8'h01 to addr=0, then read both -> 8'hFF and 8'h01, with no aliasing.
- Async mode (RAM_IS_SYNCHRONOUS=0): ram[4]=8'h5A, ren=1, addr=4 -> rdat=8'h5A in the same delta cycle; ren=0 -> rdat=8'h00.
- Hierarchical access: a task writes ram[0..31]=i, then a sequential read sweep -> rdat=i for each address with 1-cycle latency; a write of 8'hEE via the port at addr=5 is visible as ram[5]==8'hEE from the task.

Source files
------------

// File: rtl/sram_model.sv
// Behavioural single-port SRAM, 2**ADDR_WIDTH x DATA_WIDTH.
// The read path is either registered on ramclk or combinational from addr,
// chosen at elaboration time. The storage array `ram` is part of the interface:
// bench tasks preload and dump it hierarchically.
module sram_model #(
  parameter int unsigned ADDR_WIDTH         = 8,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter bit          RAM_IS_SYNCHRONOUS = 1'b1
) (
  input  logic                  ramclk,
  input  logic                  n_rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Zero at time 0. Reset never clears it, so preloaded contents survive reset.
  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1] = '{default: '0};

  logic addr_bad;
  assign addr_bad = $isunknown(addr);

  // Flag an unknown address whenever an access is requested.
  always_comb begin
    if (n_rst && (wen || ren)) begin
      assert (!addr_bad) else $error("sram_model: X/Z on addr with wen/ren active");
    end
  end

  generate
    if (RAM_IS_SYNCHRONOUS) begin : g_sync
      // Write port and read register share one block. Because of that, n_rst
      // is used only as an asynchronous reset. The read samples the old word,
      // so a same-address write/read in one cycle returns the old word.
      always_ff @(posedge ramclk or negedge n_rst) begin
        if (!n_rst) begin
          rdat <= '0;
        end else begin
          if (ren) begin
            rdat <= addr_bad ? 'x : ram[addr];
          end
          if (wen && !addr_bad) begin
            ram[addr] <= wdat;
          end
        end
      end
    end else begin : g_async
      // Write port. Writes are ignored while n_rst is low.
      always_ff @(posedge ramclk) begin
        if (n_rst && wen && !addr_bad) begin
          ram[addr] <= wdat;
        end
      end

      // Combinational read. This path does not depend on n_rst.
      always_comb begin
        rdat = '0;
        if (ren) begin
          rdat = addr_bad ? 'x : ram[addr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_model.sv
// Scoreboard bench for sram_model. A registered-read instance and a
// combinational-read instance share the same stimulus. A plain array holds the
// expected memory contents, and the expected registered read data is queued at
// each clock edge.
module tb_sram_model;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          ramclk = 1'b0;
  logic          n_rst  = 1'b0;
  logic          wen    = 1'b0;
  logic          ren    = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [DW-1:0] wdat   = '0;
  logic [DW-1:0] rdat_s;
  logic [DW-1:0] rdat_a;

  always #5 ramclk = ~ramclk;

  sram_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_IS_SYNCHRONOUS(1'b1)) dut_s (
    .ramclk(ramclk), .n_rst(n_rst), .addr(addr), .wen(wen), .ren(ren),
    .wdat(wdat), .rdat(rdat_s)
  );

  sram_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_IS_SYNCHRONOUS(1'b0)) dut_a (
    .ramclk(ramclk), .n_rst(n_rst), .addr(addr), .wen(wen), .ren(ren),
    .wdat(wdat), .rdat(rdat_a)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] last_rd = '0;

  typedef struct {
    logic [DW-1:0] val;
    string         name;
  } exp_t;
  exp_t exp_q[$];

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Monitor: registered read data is examined on each falling edge.
  always @(negedge ramclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, rdat_s, e.val);
    end
  end

  // Writes the same word into both instances and the reference array.
  task automatic preload(input int a, input logic [DW-1:0] v);
    dut_s.ram[a] = v;
    dut_a.ram[a] = v;
    mem[a]       = v;
  endtask

  // Drives one clock cycle. The combinational read is checked before the edge.
  // The expected registered value is queued at the edge.
  task automatic cycle(input logic rst_v, input logic w, input logic r,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input string name);
    logic [DW-1:0] exp_async;
    @(negedge ramclk);
    #1;
    n_rst = rst_v; wen = w; ren = r; addr = a; wdat = d;
    #1;
    exp_async = r ? mem[a] : '0;
    check({name, "/async"}, rdat_a, exp_async);
    if (!rst_v) check({name, "/rst_immediate"}, rdat_s, '0);
    @(posedge ramclk);
    if (!rst_v)  last_rd = '0;
    else if (r)  last_rd = mem[a];
    if (rst_v && w) mem[a] = d;
    exp_q.push_back('{val: last_rd, name: name});
  endtask

  initial begin
    int drain;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #1;
    preload(3, 8'hA5);

    // Reset held low while ren toggles.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, logic'(i[0]), 5'd3, 8'h00, "reset_hold");
    // A write attempted during reset must be dropped.
    cycle(1'b0, 1'b1, 1'b1, 5'd3, 8'h77, "reset_write_ignored");
    cycle(1'b1, 1'b0, 1'b1, 5'd3, 8'h00, "preload_survives");
    cycle(1'b1, 1'b0, 1'b1, 5'd12, 8'h00, "init_zero");

    // Write, then read, then hold.
    cycle(1'b1, 1'b1, 1'b0, 5'd7, 8'h3C, "write7");
    cycle(1'b1, 1'b0, 1'b1, 5'd7, 8'h00, "read7");
    cycle(1'b1, 1'b0, 1'b0, 5'd1, 8'h00, "hold7_a");
    cycle(1'b1, 1'b0, 1'b0, 5'd2, 8'h00, "hold7_b");

    // Same-address write and read in one cycle returns the old word.
    preload(9, 8'h11);
    cycle(1'b1, 1'b1, 1'b1, 5'd9, 8'h22, "collision_old");
    cycle(1'b1, 1'b0, 1'b1, 5'd9, 8'h00, "collision_new");

    // Address boundaries.
    cycle(1'b1, 1'b1, 1'b0, 5'd31, 8'hFF, "wr31");
    cycle(1'b1, 1'b1, 1'b0, 5'd0,  8'h01, "wr0");
    cycle(1'b1, 1'b0, 1'b1, 5'd31, 8'h00, "rd31");
    cycle(1'b1, 1'b0, 1'b1, 5'd0,  8'h00, "rd0");

    // Combinational read, then ren low.
    preload(4, 8'h5A);
    cycle(1'b1, 1'b0, 1'b1, 5'd4, 8'h00, "async_rd4");
    cycle(1'b1, 1'b0, 1'b0, 5'd4, 8'h00, "async_ren0");

    // Hierarchical preload, then a read sweep over every address.
    for (int i = 0; i < DEPTH; i++) preload(i, DW'(i));
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, AW'(i), 8'h00, "sweep");
    cycle(1'b1, 1'b1, 1'b0, 5'd5, 8'hEE, "port_wr5");
    #1;
    check("hier_ram5_sync",  dut_s.ram[5], 8'hEE);
    check("hier_ram5_async", dut_a.ram[5], 8'hEE);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 19) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
            DW'($urandom), "random");
    end
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, "tail");

    // Final memory contents must match the reference array.
    for (int i = 0; i < DEPTH; i++) begin
      check("final_mem_sync",  dut_s.ram[i], mem[i]);
      check("final_mem_async", dut_a.ram[i], mem[i]);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge ramclk);
      drain++;
    end
    #6;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
